// File: rtl/mic_sound_ctrl_if.sv
// Microphone path bundle: enable/PDM inputs toward the controller, status and
// loudness outputs back. The LED meter exists only when MIC_LED_METER_EN is defined.
interface mic_sound_ctrl_if;
    logic        enable_mike;
    logic        M_DATA;
    logic        mic_run;
    logic [1:0]  state;
    logic [15:0] level;
    logic        level_valid;
    logic        sound_pulse;
`ifdef MIC_LED_METER_EN
    logic [15:0] LED;

    modport master (
        output enable_mike, M_DATA,
        input  mic_run, state, level, level_valid, sound_pulse, LED
    );
    modport slave (
        input  enable_mike, M_DATA,
        output mic_run, state, level, level_valid, sound_pulse, LED
    );
`else
    modport master (
        output enable_mike, M_DATA,
        input  mic_run, state, level, level_valid, sound_pulse
    );
    modport slave (
        input  enable_mike, M_DATA,
        output mic_run, state, level, level_valid, sound_pulse
    );
`endif
endinterface

// File: rtl/mic_sound_ctrl.sv
// mic_sound_ctrl: powers the PDM microphone through a warm-up, measures pulse
// density over back-to-back 2^W-sample windows and strobes sound_pulse after
// HITS_REQ consecutive loud windows, then holds off before listening again.
// Define MIC_LED_METER_EN to add the registered LED thermometer meter.
module mic_sound_ctrl #(
    parameter int unsigned WARMUP_CYCLES  = 25000,
    parameter int unsigned WINDOW_LOG2    = 12,
    parameter int unsigned DEV_THRESH     = 512,
    parameter int unsigned HITS_REQ       = 2,
    parameter int unsigned HOLDOFF_CYCLES = 1250000
) (
    input  logic            pulse_2dot5MHz,
    input  logic            reset,
    mic_sound_ctrl_if.slave mic
);
    localparam int unsigned W       = WINDOW_LOG2;
    localparam int unsigned CYC_MAX = (WARMUP_CYCLES > HOLDOFF_CYCLES) ? WARMUP_CYCLES
                                                                       : HOLDOFF_CYCLES;
    localparam int unsigned CYC_W   = (CYC_MAX > 1) ? $clog2(CYC_MAX) : 1;
    localparam int unsigned HIT_W   = $clog2(HITS_REQ + 1);
    localparam logic [W:0]  HALF    = (W+1)'(2 ** (W - 1));

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WARMUP  = 2'd1,
        LISTEN  = 2'd2,
        HOLDOFF = 2'd3
    } state_t;

    state_t           state_q;
    logic             mic_run_q;
    logic [CYC_W-1:0] cyc_q;
    logic [W-1:0]     win_q;
    logic [W:0]       ones_q;
    logic [HIT_W-1:0] hits_q;
    logic [15:0]      level_q;
    logic             level_valid_q;
    logic             sound_pulse_q;

    logic [W:0]       tot_d;
    logic [W-1:0]     dev_d;
    logic [HIT_W-1:0] hits_inc_d;
    logic             win_end_d;
    logic             loud_d;
    logic             fire_d;

    // Window arithmetic: running total including this sample and its distance from half scale.
    always_comb begin
        tot_d      = ones_q + (W+1)'(mic.M_DATA);
        dev_d      = (tot_d >= HALF) ? W'(tot_d - HALF) : W'(HALF - tot_d);
        win_end_d  = &win_q;
        hits_inc_d = hits_q + HIT_W'(1);
        loud_d     = 32'(dev_d) >= DEV_THRESH;
        fire_d     = loud_d && (32'(hits_inc_d) == HITS_REQ);
    end

`ifdef MIC_LED_METER_EN
    logic [15:0] led_q;
    logic [31:0] led_n_d;
    logic [15:0] led_d;

    // Thermometer bar: lit count scales deviation so half scale lights all 16.
    always_comb begin
        led_n_d = (32'(dev_d) << 4) >> (W - 1);
        if (led_n_d > 32'd16) begin
            led_n_d = 32'd16;
        end
        led_d = 16'((32'd1 << led_n_d) - 32'd1);
    end
`endif

    // Sequencer: disable overrides everything; windows end on the all-ones window count.
    always_ff @(posedge pulse_2dot5MHz) begin
        if (reset) begin
            state_q       <= IDLE;
            mic_run_q     <= 1'b0;
            cyc_q         <= '0;
            win_q         <= '0;
            ones_q        <= '0;
            hits_q        <= '0;
            level_q       <= '0;
            level_valid_q <= 1'b0;
            sound_pulse_q <= 1'b0;
`ifdef MIC_LED_METER_EN
            led_q         <= '0;
`endif
        end else begin
            level_valid_q <= 1'b0;
            sound_pulse_q <= 1'b0;
            if (!mic.enable_mike) begin
                state_q   <= IDLE;
                mic_run_q <= 1'b0;
                cyc_q     <= '0;
                win_q     <= '0;
                ones_q    <= '0;
                hits_q    <= '0;
                level_q   <= '0;
`ifdef MIC_LED_METER_EN
                led_q     <= '0;
`endif
            end else begin
                case (state_q)
                    IDLE: begin
                        state_q   <= WARMUP;
                        mic_run_q <= 1'b1;
                        cyc_q     <= '0;
                    end
                    WARMUP: begin
                        if (cyc_q == CYC_W'(WARMUP_CYCLES - 1)) begin
                            state_q <= LISTEN;
                            cyc_q   <= '0;
                            win_q   <= '0;
                            ones_q  <= '0;
                            hits_q  <= '0;
                        end else begin
                            cyc_q <= cyc_q + CYC_W'(1);
                        end
                    end
                    LISTEN: begin
                        if (win_end_d) begin
                            win_q         <= '0;
                            ones_q        <= '0;
                            level_q       <= 16'(dev_d);
                            level_valid_q <= 1'b1;
`ifdef MIC_LED_METER_EN
                            led_q         <= led_d;
`endif
                            if (fire_d) begin
                                sound_pulse_q <= 1'b1;
                                hits_q        <= '0;
                                state_q       <= HOLDOFF;
                                cyc_q         <= '0;
                            end else if (loud_d) begin
                                hits_q <= hits_inc_d;
                            end else begin
                                hits_q <= '0;
                            end
                        end else begin
                            ones_q <= tot_d;
                            win_q  <= win_q + W'(1);
                        end
                    end
                    HOLDOFF: begin
                        if (cyc_q == CYC_W'(HOLDOFF_CYCLES - 1)) begin
                            state_q <= LISTEN;
                            cyc_q   <= '0;
                            win_q   <= '0;
                            ones_q  <= '0;
                        end else begin
                            cyc_q <= cyc_q + CYC_W'(1);
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign mic.mic_run     = mic_run_q;
    assign mic.state       = state_q;
    assign mic.level       = level_q;
    assign mic.level_valid = level_valid_q;
    assign mic.sound_pulse = sound_pulse_q;
`ifdef MIC_LED_METER_EN
    assign mic.LED         = led_q;
`endif

endmodule

// File: tb/tb_mic_sound_ctrl.sv
// Directed + randomized bench for mic_sound_ctrl with small timing parameters.
// Window results are predicted from sample counts of each driven window.
module tb_mic_sound_ctrl;
    localparam int unsigned WARMUP = 8;
    localparam int unsigned WLOG   = 4;
    localparam int unsigned THRESH = 6;
    localparam int unsigned HREQ   = 2;
    localparam int unsigned HOLD   = 20;
    localparam int          WIN    = 16;
    localparam int          HALFW  = 8;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    mic_sound_ctrl_if bus ();

    mic_sound_ctrl #(
        .WARMUP_CYCLES  (WARMUP),
        .WINDOW_LOG2    (WLOG),
        .DEV_THRESH     (THRESH),
        .HITS_REQ       (HREQ),
        .HOLDOFF_CYCLES (HOLD)
    ) dut (
        .pulse_2dot5MHz (clk),
        .reset          (rst),
        .mic            (bus.slave)
    );

    int errors = 0;
    int checks = 0;
    int model_hits = 0;
    int model_level = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

`ifdef MIC_LED_METER_EN
    function automatic logic [15:0] bar_of(input int dev);
        logic [15:0] b;
        int lit;
        lit = (dev * 16) / HALFW;
        if (lit > 16) lit = 16;
        b = '0;
        for (int i = 0; i < lit; i++) b[i] = 1'b1;
        return b;
    endfunction
`endif

    // Expect WARMUP from the next edge, then LISTEN exactly WARMUP edges later.
    task automatic warmup_seq(input string tag);
        tick();
        chk({tag, ".state_warm"}, 32'(bus.state), 32'd1);
        chk({tag, ".mic_run"}, 32'(bus.mic_run), 32'd1);
        for (int i = 1; i < int'(WARMUP); i++) begin
            bus.M_DATA = 1'($urandom);
            tick();
            chk({tag, ".state_still_warm"}, 32'(bus.state), 32'd1);
        end
        bus.M_DATA = 1'($urandom);
        tick();
        chk({tag, ".state_listen"}, 32'(bus.state), 32'd2);
        chk({tag, ".lv_idle"}, 32'(bus.level_valid), 32'd0);
    endtask

    // Drive one full window and compare against the sample-count prediction.
    task automatic run_window(input string tag, input logic [15:0] pat);
        int ones;
        int dev;
        bit loud;
        bit fire;
        ones = 0;
        for (int i = 0; i < WIN; i++) begin
            bus.M_DATA = pat[i];
            ones += int'(pat[i]);
            tick();
            if (i < WIN - 1) begin
                chk({tag, ".lv_mid"}, 32'(bus.level_valid), 32'd0);
            end
        end
        dev  = (ones > HALFW) ? ones - HALFW : HALFW - ones;
        loud = dev >= int'(THRESH);
        model_hits = loud ? model_hits + 1 : 0;
        fire = (model_hits == int'(HREQ));
        if (fire) model_hits = 0;
        model_level = dev;
        chk({tag, ".lv_end"}, 32'(bus.level_valid), 32'd1);
        chk({tag, ".level"}, 32'(bus.level), 32'(model_level));
        chk({tag, ".pulse"}, 32'(bus.sound_pulse), 32'(fire));
        chk({tag, ".state"}, 32'(bus.state), fire ? 32'd3 : 32'd2);
`ifdef MIC_LED_METER_EN
        chk({tag, ".led"}, 32'(bus.LED), 32'(bar_of(dev)));
`endif
        if (fire) begin
            for (int i = 1; i < int'(HOLD); i++) begin
                bus.M_DATA = 1'($urandom);
                tick();
                chk({tag, ".hold_state"}, 32'(bus.state), 32'd3);
                chk({tag, ".hold_pulse"}, 32'(bus.sound_pulse), 32'd0);
            end
            bus.M_DATA = 1'($urandom);
            tick();
            chk({tag, ".hold_exit"}, 32'(bus.state), 32'd2);
            chk({tag, ".hold_level"}, 32'(bus.level), 32'(model_level));
            chk({tag, ".hold_lv"}, 32'(bus.level_valid), 32'd0);
        end
    endtask

    initial begin
        logic [15:0] pat;

        // Reset dominates a high enable.
        rst = 1'b1;
        bus.enable_mike = 1'b1;
        bus.M_DATA = 1'b0;
        repeat (3) tick();
        chk("rst.state", 32'(bus.state), 32'd0);
        chk("rst.mic_run", 32'(bus.mic_run), 32'd0);
        chk("rst.level", 32'(bus.level), 32'd0);
        chk("rst.lv", 32'(bus.level_valid), 32'd0);
        chk("rst.pulse", 32'(bus.sound_pulse), 32'd0);
`ifdef MIC_LED_METER_EN
        chk("rst.led", 32'(bus.LED), 32'd0);
`endif
        rst = 1'b0;
        warmup_seq("start");

        // Quiet, then sustained loud with detection and holdoff, then broken run.
        run_window("quiet0", 16'h5555);
        run_window("quiet1", 16'hAAAA);
        run_window("quiet2", 16'h5555);
        run_window("loud1", 16'hFFFF);
        run_window("loud2", 16'hFFFF);
        run_window("after_hold", 16'h5555);
        run_window("brk1", 16'hFFFF);
        run_window("brk2", 16'h5555);
        run_window("brk3", 16'hFFFF);

        // Drop enable mid-window with one loud hit pending.
        for (int i = 0; i < 7; i++) begin
            bus.M_DATA = 1'b1;
            tick();
        end
        bus.enable_mike = 1'b0;
        tick();
        model_hits = 0;
        model_level = 0;
        chk("dis.state", 32'(bus.state), 32'd0);
        chk("dis.mic_run", 32'(bus.mic_run), 32'd0);
        chk("dis.level", 32'(bus.level), 32'd0);
        chk("dis.lv", 32'(bus.level_valid), 32'd0);
`ifdef MIC_LED_METER_EN
        chk("dis.led", 32'(bus.LED), 32'd0);
`endif
        tick();
        chk("dis.idle_hold", 32'(bus.state), 32'd0);
        bus.enable_mike = 1'b1;
        warmup_seq("reen");
        run_window("reen_loud", 16'hFFFF);
        run_window("twelve", 16'h0FFF);

        // Randomized windows biased toward loud densities.
        for (int w = 0; w < 14; w++) begin
            case ($urandom_range(0, 3))
                0:       pat = 16'($urandom);
                1:       pat = 16'hFFFF ^ (16'($urandom) & 16'($urandom) & 16'($urandom));
                2:       pat = 16'($urandom) & 16'($urandom) & 16'($urandom);
                default: pat = 16'hFFFF;
            endcase
            run_window("rand", pat);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
